text_buffer_writer: RTL
=======================

Name: text_buffer_writer

Overview:
Writer side of the OLED text display path: accepts a byte stream of ASCII characters and control codes and maintains the character buffer that the text engine reads to render glyphs. It holds a ROWS x COLS character array with a cursor and handles printable characters, CR, LF, backspace and form-feed. A combinational read port gives the text engine the same char-address lookup it uses today. The byte stream typically comes from a UART receiver or a test-pattern sequencer.

Parameters:
ROWS, 4, number of text rows (power of 2, >=2)
COLS, 16, characters per row (power of 2, >=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a byte to consume
in_data  input  8  ASCII byte or control code
in_ready  output  1  block can accept a byte this cycle
rd_addr  input  log2(ROWS*COLS)  char address, row*COLS+col (6 bits at defaults)
rd_data  output  8  buffer[rd_addr], combinational
cursor_row  output  log2(ROWS)  current cursor row
cursor_col  output  log2(COLS)  current cursor column
busy  output  1  CLEAR or SCROLL in progress

Behaviour:
- Reset is asynchronous and active-low. On assert: state=CLEAR, sweep index=0, cursor=(0,0), in_ready=0, busy=1. The buffer is not reset directly; the CLEAR sweep fills it.
- Applies equally mid-CLEAR, mid-SCROLL or mid-write: the operation is abandoned and CLEAR restarts from index 0.
- States: CLEAR, IDLE, SCROLL (SCROLL exists only with the optional feature).
- CLEAR: writes 0x20 to one entry per cycle, index 0..ROWS*COLS-1 (64 cycles at defaults). Then IDLE; in_ready=1 and busy=0 from the following cycle.
- IDLE: in_ready=1. A byte is accepted on a rising edge when in_valid && in_ready. Exactly one byte is accepted per cycle; there is no internal FIFO.
- Accepted byte handling, all effects on the acceptance edge:
  - 0x20..0x7E: written at (row,col). Col advances; if col was COLS-1, col=0 and the newline rule applies.
  - 0x0A LF: col=0, newline rule.
  - 0x0D CR: col=0, row unchanged.
  - 0x08 BS: if col>0, col-1 and write 0x20 at the new position. If col==0, no-op; the cursor never moves to the previous row.
  - 0x0C FF: cursor=(0,0), enter CLEAR (full 64-cycle sweep, in_ready=0).
  - Any other byte: consumed and ignored, no state change.
- Newline rule: if row<ROWS-1, row+1. Otherwise, without the feature, row wraps to 0 and existing content is kept.
- Write/read latency: a byte accepted at edge N appears on rd_data (for the matching rd_addr) after edge N. The cursor outputs update at edge N.
- rd_data is a purely combinational array read. During CLEAR/SCROLL it returns in-progress contents; the text engine tolerates one frame of tearing.
- Arithmetic: cursor counters are exact-width and wrap naturally. The buffer index is {row,col}.
- in_valid while in_ready=0: not consumed. The source must hold the byte, and the block must not sample it.

Optional Feature:
TEXT_SCROLL_EN
- Defined: a newline rule on the last row enters SCROLL instead of wrapping. The triggering character is still written first.
  - SCROLL copies buffer[i+COLS] to buffer[i] for i=0..(ROWS-1)*COLS-1, one per cycle, then writes 0x20 to the COLS entries of the last row.
  - Total ROWS*COLS cycles. Cursor=(ROWS-1,0). in_ready=0 and busy=1 throughout, then IDLE.
- Undefined: no SCROLL state or logic; the last row wraps to row 0 as described above.

Test Plan:
- Reset, hold in_valid=0 -> in_ready=0 for 64 cycles, then 1; every rd_addr 0..63 reads 0x20; cursor=(0,0).
- Send "Lushay" -> rd_addr 0..5 read 4C 75 73 68 61 79; cursor=(0,6). Then send 0x08 -> rd_addr 5 = 0x20, cursor=(0,5).
- Send 16x 'A' then 'B' -> addr 0..15 = 0x41, addr 16 = 0x42, cursor=(1,1). Send 0x0D -> cursor=(1,0). Send 0x08 -> no change.
- Cursor at (3,15), send 'Z': without the feature, addr 63 = 0x5A and cursor=(0,0). With TEXT_SCROLL_EN, busy=1 for 64 cycles; old row 3 content (including 'Z') ends at addr 32..47, addr 48..63 = 0x20, cursor=(3,0).
- Send 0x0C with in_valid held high and the next byte 'Q' -> in_ready=0 for 64 cycles, 'Q' is not consumed early, buffer is all 0x20, then 'Q' lands at addr 0.
- Assert rst_n=0 for 1 cycle midway through a CLEAR or SCROLL -> outputs go immediately to reset values; a full 64-cycle CLEAR follows.

Source files
------------

// File: rtl/text_buffer_writer.sv
// text_buffer_writer: writer side of the OLED text path. Turns an ASCII/control
// byte stream into a ROWS x COLS character buffer with a cursor.
// Ports: clk, rst_n (async, active-low); in_valid/in_data/in_ready byte input;
//   rd_addr/rd_data combinational buffer read; cursor_row/cursor_col; busy.
// Optional: define TEXT_SCROLL_EN to scroll up on last-row newline instead of
//   wrapping to row 0.
module text_buffer_writer #(
    parameter int ROWS = 4,
    parameter int COLS = 16,
    localparam int N  = ROWS * COLS,
    localparam int AW = $clog2(N),
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [RW-1:0] cursor_row,
    output logic [CW-1:0] cursor_col,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE
`ifdef TEXT_SCROLL_EN
        , S_SCROLL
`endif
    } state_t;

    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [RW-1:0] RLAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] CLAST = CW'(COLS - 1);
`ifdef TEXT_SCROLL_EN
    localparam logic [AW-1:0] SHIFT_N = AW'((ROWS - 1) * COLS);
    localparam logic [AW-1:0] COLS_A  = AW'(COLS);
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    logic [7:0]    mem_q [N];
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          nl;
    logic [CW-1:0] col_dec;

    assign col_dec = col_q - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Buffer storage has no reset; the CLEAR sweep initialises it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        we      = 1'b0;
        waddr   = idx_q;
        wdata   = 8'h20;
        nl      = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                we    = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    unique case (1'b1)
                        (in_data >= 8'h20 && in_data <= 8'h7E): begin
                            we    = 1'b1;
                            waddr = {row_q, col_q};
                            wdata = in_data;
                            col_d = col_q + 1'b1;
                            nl    = (col_q == CLAST);
                        end
                        (in_data == 8'h0A): begin
                            col_d = '0;
                            nl    = 1'b1;
                        end
                        (in_data == 8'h0D): begin
                            col_d = '0;
                        end
                        (in_data == 8'h08): begin
                            if (col_q != '0) begin
                                col_d = col_dec;
                                we    = 1'b1;
                                waddr = {row_q, col_dec};
                            end
                        end
                        (in_data == 8'h0C): begin
                            row_d   = '0;
                            col_d   = '0;
                            idx_d   = '0;
                            state_d = S_CLEAR;
                        end
                        default: ;
                    endcase
                    if (nl) begin
                        if (row_q != RLAST) begin
                            row_d = row_q + 1'b1;
                        end else begin
`ifdef TEXT_SCROLL_EN
                            state_d = S_SCROLL;
                            idx_d   = '0;
`else
                            row_d   = '0;
`endif
                        end
                    end
                end
            end
`ifdef TEXT_SCROLL_EN
            // Shift rows up one entry per cycle, then blank the last row.
            S_SCROLL: begin
                we    = 1'b1;
                wdata = (idx_q < SHIFT_N) ? mem_q[idx_q + COLS_A] : 8'h20;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
`endif
            default: begin
                state_d = S_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rd_data    = mem_q[rd_addr];
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule
